// File: rtl/ni_flit_injector.sv
// NoC endpoint flit injector: packet requests plus payload words become
// head/body/tail flits on one VC per packet, gated by per-VC credit counters.
module ni_flit_injector #(
   parameter int V    = 4,
   parameter int B    = 4,
   parameter int Fpay = 32,
   parameter int DSTw = 8,
   parameter int LENw = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DSTw-1:0]      src_id,
   input  logic                 pkt_req_valid,
   output logic                 pkt_req_ready,
   input  logic [DSTw-1:0]      pkt_dest,
   input  logic [$clog2(V)-1:0] pkt_vc,
   input  logic [LENw-1:0]      pkt_len,
   input  logic                 data_valid,
   output logic                 data_ready,
   input  logic [Fpay-1:0]      data_in,
   output logic                 flit_wr,
   output logic                 flit_hdr,
   output logic                 flit_tail,
   output logic [V-1:0]         flit_vc,
   output logic [Fpay-1:0]      flit_payload,
   input  logic [V-1:0]         credit_in,
   output logic                 busy,
   output logic                 credit_err
);

   localparam int VCw  = $clog2(V);
   localparam int CNTw = $clog2(B + 1);

   typedef enum logic {
      IDLE,
      BODY
   } state_e;

   state_e                    state_q, state_d;
   logic [VCw-1:0]            vc_q, vc_d;
   logic [LENw-1:0]           rem_q, rem_d;
   logic [V-1:0][CNTw-1:0]    cnt_q, cnt_d;
   logic                      err_q, err_d;
   logic                      wr_q, wr_d;
   logic                      hdr_q, hdr_d;
   logic                      tail_q, tail_d;
   logic [V-1:0]              vco_q, vco_d;
   logic [Fpay-1:0]           pay_q, pay_d;
   logic [V-1:0]              sent;
   logic [LENw-1:0]           len_eff;
   logic [LENw-1:0]           rem_new;

   assign len_eff = (pkt_len == '0) ? LENw'(1) : pkt_len;
   assign rem_new = len_eff - LENw'(1);

   // Packet FSM: accepts requests, emits head/body/tail and picks the sending VC
   always_comb begin
      state_d       = state_q;
      vc_d          = vc_q;
      rem_d         = rem_q;
      wr_d          = 1'b0;
      hdr_d         = 1'b0;
      tail_d        = 1'b0;
      vco_d         = '0;
      pay_d         = '0;
      sent          = '0;
      pkt_req_ready = 1'b0;
      data_ready    = 1'b0;
      unique case (state_q)
         IDLE: begin
            pkt_req_ready = (cnt_q[pkt_vc] != '0);
            if (pkt_req_valid && pkt_req_ready) begin
               sent[pkt_vc]  = 1'b1;
               wr_d          = 1'b1;
               hdr_d         = 1'b1;
               tail_d        = (rem_new == '0);
               vco_d[pkt_vc] = 1'b1;
               pay_d[DSTw-1:0]                 = pkt_dest;
               pay_d[2*DSTw-1:DSTw]            = src_id;
               pay_d[2*DSTw+LENw-1:2*DSTw]     = pkt_len;
               vc_d          = pkt_vc;
               rem_d         = rem_new;
               if (rem_new != '0) begin
                  state_d = BODY;
               end
            end
         end
         BODY: begin
            data_ready = (cnt_q[vc_q] != '0);
            if (data_valid && data_ready) begin
               sent[vc_q]  = 1'b1;
               wr_d        = 1'b1;
               tail_d      = (rem_q == LENw'(1));
               vco_d[vc_q] = 1'b1;
               pay_d       = data_in;
               rem_d       = rem_q - LENw'(1);
               if (rem_q == LENw'(1)) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Credit bookkeeping: send and return cancel; a return into a full counter is an error
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      for (int v = 0; v < V; v++) begin
         if (credit_in[v] && !sent[v]) begin
            if (cnt_q[v] == CNTw'(B)) begin
               err_d = 1'b1;
            end else begin
               cnt_d[v] = cnt_q[v] + CNTw'(1);
            end
         end else if (sent[v] && !credit_in[v]) begin
            cnt_d[v] = cnt_q[v] - CNTw'(1);
         end
      end
   end

   // State, credit and registered flit outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         vc_q    <= '0;
         rem_q   <= '0;
         for (int v = 0; v < V; v++) begin
            cnt_q[v] <= CNTw'(B);
         end
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
         hdr_q   <= 1'b0;
         tail_q  <= 1'b0;
         vco_q   <= '0;
         pay_q   <= '0;
      end else begin
         state_q <= state_d;
         vc_q    <= vc_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         wr_q    <= wr_d;
         hdr_q   <= hdr_d;
         tail_q  <= tail_d;
         vco_q   <= vco_d;
         pay_q   <= pay_d;
      end
   end

   assign flit_wr      = wr_q;
   assign flit_hdr     = hdr_q;
   assign flit_tail    = tail_q;
   assign flit_vc      = vco_q;
   assign flit_payload = pay_q;
   assign busy         = (state_q != IDLE);
   assign credit_err   = err_q;

endmodule
